// File: rtl/execute_stage_if.sv
// Register-fetch / execute / writeback handshake bundle for the rvga
// integer execute stage. The master side is the register-fetch and
// writeback environment; the execute stage itself uses the slave side.
interface execute_stage_if #(
    parameter int width_p          = 32,
    parameter int reg_addr_width_p = 5
);
    logic                        rfetch_execute_v;
    logic [reg_addr_width_p-1:0] rfetch_execute_rs1;
    logic [reg_addr_width_p-1:0] rfetch_execute_rs2;
    logic [reg_addr_width_p-1:0] rfetch_execute_rd;
    logic [width_p-1:0]          rfetch_execute_rs1_data;
    logic [width_p-1:0]          rfetch_execute_rs2_data;
    logic [width_p-1:0]          rfetch_execute_imm_data;
    logic                        rfetch_execute_imm_v;
    logic [2:0]                  rfetch_execute_artop;
    logic                        rfetch_execute_alt_art;
    logic                        execute_rfetch_stall;

    logic                        writeback_execute_rd_w_v;
    logic [reg_addr_width_p-1:0] writeback_execute_rd;
    logic [width_p-1:0]          writeback_execute_rd_data;

    logic                        execute_writeback_v;
    logic [reg_addr_width_p-1:0] execute_writeback_rd;
    logic                        execute_writeback_rd_w_v;
    logic [width_p-1:0]          execute_writeback_rd_data;

    modport master (
        output rfetch_execute_v, rfetch_execute_rs1, rfetch_execute_rs2,
               rfetch_execute_rd, rfetch_execute_rs1_data, rfetch_execute_rs2_data,
               rfetch_execute_imm_data, rfetch_execute_imm_v, rfetch_execute_artop,
               rfetch_execute_alt_art,
               writeback_execute_rd_w_v, writeback_execute_rd, writeback_execute_rd_data,
        input  execute_rfetch_stall,
               execute_writeback_v, execute_writeback_rd, execute_writeback_rd_w_v,
               execute_writeback_rd_data
    );

    modport slave (
        input  rfetch_execute_v, rfetch_execute_rs1, rfetch_execute_rs2,
               rfetch_execute_rd, rfetch_execute_rs1_data, rfetch_execute_rs2_data,
               rfetch_execute_imm_data, rfetch_execute_imm_v, rfetch_execute_artop,
               rfetch_execute_alt_art,
               writeback_execute_rd_w_v, writeback_execute_rd, writeback_execute_rd_data,
        output execute_rfetch_stall,
               execute_writeback_v, execute_writeback_rd, execute_writeback_rd_w_v,
               execute_writeback_rd_data
    );
endinterface

// File: rtl/execute_stage.sv
// rvga integer execute stage: two-level operand bypass, RV32I ALU, and a
// 1-bit-per-cycle iterative shifter that stalls register-fetch while busy.
module execute_stage #(
    parameter int width_p          = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                      state_q;
    logic [4:0]                  cnt_q;
    logic [width_p-1:0]          sh_q;
    logic                        left_q;
    logic                        arith_q;
    logic [reg_addr_width_p-1:0] rd_pend_q;

    logic                        v_q;
    logic [reg_addr_width_p-1:0] rd_q;
    logic                        rd_w_v_q;
    logic [width_p-1:0]          rd_data_q;

    logic [width_p-1:0]          op_a;
    logic [width_p-1:0]          op_b;
    logic [width_p-1:0]          result_d;
    logic [width_p-1:0]          sh_d;
    logic                        is_shift;
    logic [4:0]                  shamt;

    // Operand resolution: our own output register beats the writeback stage,
    // which beats the (possibly stale) regfile data.
    always_comb begin
        op_a = bus.rfetch_execute_rs1_data;
        if (v_q && rd_w_v_q && rd_q == bus.rfetch_execute_rs1)
            op_a = rd_data_q;
        else if (bus.writeback_execute_rd_w_v && bus.writeback_execute_rd == bus.rfetch_execute_rs1
                 && bus.rfetch_execute_rs1 != '0)
            op_a = bus.writeback_execute_rd_data;

        op_b = bus.rfetch_execute_rs2_data;
        if (v_q && rd_w_v_q && rd_q == bus.rfetch_execute_rs2)
            op_b = rd_data_q;
        else if (bus.writeback_execute_rd_w_v && bus.writeback_execute_rd == bus.rfetch_execute_rs2
                 && bus.rfetch_execute_rs2 != '0)
            op_b = bus.writeback_execute_rd_data;
        if (bus.rfetch_execute_imm_v)
            op_b = bus.rfetch_execute_imm_data;
    end

    assign shamt    = op_b[4:0];
    assign is_shift = (bus.rfetch_execute_artop == 3'b001) || (bus.rfetch_execute_artop == 3'b101);

    // Single-cycle ALU; shifts only land here with shamt=0, so they pass A through.
    always_comb begin
        result_d = '0;
        case (bus.rfetch_execute_artop)
            3'b000:  result_d = (bus.rfetch_execute_alt_art && !bus.rfetch_execute_imm_v)
                                ? op_a - op_b : op_a + op_b;
            3'b010:  result_d = {{(width_p-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011:  result_d = {{(width_p-1){1'b0}}, op_a < op_b};
            3'b100:  result_d = op_a ^ op_b;
            3'b110:  result_d = op_a | op_b;
            3'b111:  result_d = op_a & op_b;
            default: result_d = op_a;
        endcase
    end

    // One-bit shift step of the iterative shifter.
    always_comb begin
        if (left_q)
            sh_d = {sh_q[width_p-2:0], 1'b0};
        else
            sh_d = {arith_q & sh_q[width_p-1], sh_q[width_p-1:1]};
    end

    // Control FSM plus registered writeback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
            rd_pend_q <= '0;
            v_q       <= 1'b0;
            rd_q      <= '0;
            rd_w_v_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            v_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.rfetch_execute_v) begin
                        if (is_shift && shamt != 5'd0) begin
                            sh_q      <= op_a;
                            cnt_q     <= shamt;
                            left_q    <= (bus.rfetch_execute_artop == 3'b001);
                            arith_q   <= bus.rfetch_execute_alt_art;
                            rd_pend_q <= bus.rfetch_execute_rd;
                            state_q   <= SHIFT;
                        end else begin
                            v_q       <= 1'b1;
                            rd_q      <= bus.rfetch_execute_rd;
                            rd_w_v_q  <= (bus.rfetch_execute_rd != '0);
                            rd_data_q <= result_d;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        v_q       <= 1'b1;
                        rd_q      <= rd_pend_q;
                        rd_w_v_q  <= (rd_pend_q != '0);
                        rd_data_q <= sh_d;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.execute_rfetch_stall      = (state_q == SHIFT);
    assign bus.execute_writeback_v       = v_q;
    assign bus.execute_writeback_rd      = rd_q;
    assign bus.execute_writeback_rd_w_v  = rd_w_v_q;
    assign bus.execute_writeback_rd_data = rd_data_q;
endmodule
